// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester owns the access in flight
//   MEM_LAT_MAX / CNT_W : upper bound on memory latency and the counter width that covers it
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W = $clog2(MEM_LAT_MAX + 1);
endpackage

// File: rtl/sat_counter32.sv
// 32-bit saturating event counter.
//   clk      : clock
//   clr      : synchronous clear, highest priority
//   en       : count one event this cycle
//   load     : synchronous preload of load_val
//   load_val : preload value
//   count    : current value, sticks at 32'hFFFF_FFFF
module sat_counter32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] count
);
  always_ff @(posedge clk) begin
    if (clr)                               count <= '0;
    else if (load)                         count <= load_val;
    else if (en && count != 32'hFFFF_FFFF) count <= count + 32'd1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// the MEM-stage load/store. Data requests win over fetches (older
// instruction). Each access holds the memory for MEM_LAT cycles, then a
// DONE cycle pulses the owner's ready; stall holds the pipeline until every
// pending request has been served.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   if_req/if_addr           : fetch request, if_rdata/if_ready fetch result
//   d_req/d_we/d_addr/d_wdata: load/store request, d_rdata/d_ready result
//   stall                    : pipeline freeze
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory side
//   perf_stall, perf_conf    : performance counters
// Build option: define MEM_ARB_PERF_EN to enable the performance counters;
// otherwise they read as 0 and no counter flops exist.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_conf
);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

  state_t            state, state_nxt;
  owner_t            owner;
  logic              lat_we;
  logic [AW-1:0]     lat_addr;
  logic [DW-1:0]     lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              i_served, d_served;
  logic              pending_d, pending_i, busy;

  // A request stays pending until served; the served flag masks the
  // still-held request until the pipeline actually advances.
  assign pending_d = d_req  & ~d_served;
  assign pending_i = if_req & ~i_served;
  assign stall     = pending_d | pending_i;
  assign busy      = (state == BUSY_I) || (state == BUSY_D);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:           if (pending_d)      state_nxt = BUSY_D;
                      else if (pending_i) state_nxt = BUSY_I;
      BUSY_I, BUSY_D: if (cnt == '0)      state_nxt = DONE;
      DONE:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // Outputs: memory bus is driven only while busy so it reads 0 otherwise
  always_comb begin
    mem_en    = busy;
    mem_we    = (state == BUSY_D) && lat_we;
    mem_addr  = busy ? lat_addr  : '0;
    mem_wdata = busy ? lat_wdata : '0;
    if_ready  = (state == DONE) && (owner == OWN_I);
    d_ready   = (state == DONE) && (owner == OWN_D);
  end

  // Request latch, latency counter, read-data capture, served flags
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_I;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      i_served  <= 1'b0;
      d_served  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending_d) begin
            owner     <= OWN_D;
            lat_we    <= d_we;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            cnt       <= LAT_INIT;
          end else if (pending_i) begin
            owner     <= OWN_I;
            lat_we    <= 1'b0;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            cnt       <= LAT_INIT;
          end
        end
        BUSY_I, BUSY_D: begin
          if (cnt != '0)             cnt      <= cnt - CNT_W'(1);
          else if (state == BUSY_I)  if_rdata <= mem_rdata;
          else if (!lat_we)          d_rdata  <= mem_rdata;
        end
        default: ;
      endcase

      // Clear when the pipeline advances; a completing access still marks
      // its owner served even if the request was dropped mid-access.
      if (!stall) begin
        i_served <= 1'b0;
        d_served <= 1'b0;
      end
      if (state == DONE) begin
        if (owner == OWN_D) d_served <= 1'b1;
        else                i_served <= 1'b1;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  sat_counter32 u_perf_stall (
    .clk(clk), .clr(rst), .en(stall), .load(1'b0), .load_val(32'd0), .count(perf_stall)
  );
  sat_counter32 u_perf_conf (
    .clk(clk), .clr(rst), .en(pending_d & pending_i), .load(1'b0), .load_val(32'd0),
    .count(perf_conf)
  );
`else
  assign perf_stall = '0;
  assign perf_conf  = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: MEM_LAT=2
  logic        rst = 1'b1;
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, perf_stall, perf_conf;
  logic        if_ready, d_ready, stall, mem_en, mem_we;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .perf_stall(perf_stall), .perf_conf(perf_conf)
  );

  // DUT B: MEM_LAT=1, fetch side only
  logic        b_if_req = 0;
  logic [31:0] b_if_addr = 0, b_mem_rdata = 0;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_perf_stall, b_perf_conf;
  logic        b_if_ready, b_d_ready, b_stall, b_mem_en, b_mem_we;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
    .if_ready(b_if_ready), .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready), .stall(b_stall), .mem_en(b_mem_en),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .perf_stall(b_perf_stall), .perf_conf(b_perf_conf)
  );

  // Standalone saturating counter (preload path)
  logic        sc_clr = 1, sc_en = 0, sc_load = 0;
  logic [31:0] sc_load_val = 0, sc_count;
  sat_counter32 u_sat (
    .clk(clk), .clr(sc_clr), .en(sc_en), .load(sc_load), .load_val(sc_load_val), .count(sc_count)
  );

  // Move to just after the next rising edge (start of a new cycle)
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    @(negedge clk);
    checks++; if ({if_ready, d_ready, stall, mem_en, mem_we} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {if_ready, d_ready, stall, mem_en, mem_we}); end
    checks++; if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'd0) begin errors++;
      $display("FAIL reset_data: got %h expected 0", {if_rdata, d_rdata, mem_addr, mem_wdata}); end
    checks++; if ({perf_stall, perf_conf} !== 64'd0) begin errors++;
      $display("FAIL reset_perf: got %h expected 0", {perf_stall, perf_conf}); end
    checks++; if ({b_if_ready, b_d_ready, b_stall, b_mem_en, b_if_rdata} !== 36'd0) begin errors++;
      $display("FAIL reset_b: got %h expected 0", {b_if_ready, b_d_ready, b_stall, b_mem_en, b_if_rdata}); end
  endtask

  // Fetch only: busy t+1..t+2, if_ready at t+3, stall released at t+4
  task automatic test_fetch();
    cyc(); if_req = 1; if_addr = 32'h0000_0040;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc();
      mem_rdata = (k == 2) ? 32'h2008_0005 : (32'hEEEE_0000 | 32'(k));
      @(negedge clk);
      checks++; if (mem_en !== (k == 1 || k == 2)) begin errors++;
        $display("FAIL fetch_en[%0d]: got %b expected %b", k, mem_en, (k == 1 || k == 2)); end
      checks++; if (stall !== (k <= 3)) begin errors++;
        $display("FAIL fetch_stall[%0d]: got %b expected %b", k, stall, (k <= 3)); end
      checks++; if (if_ready !== (k == 3) || d_ready !== 1'b0) begin errors++;
        $display("FAIL fetch_ready[%0d]: got %b%b expected %b0", k, if_ready, d_ready, (k == 3)); end
      if (k == 1 || k == 2) begin
        checks++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin errors++;
          $display("FAIL fetch_addr[%0d]: got %h/%b expected 00000040/0", k, mem_addr, mem_we); end
      end
      if (k >= 3) begin
        checks++; if (if_rdata !== 32'h2008_0005) begin errors++;
          $display("FAIL fetch_rdata[%0d]: got %h expected 20080005", k, if_rdata); end
      end
    end
    if_req = 0;
  endtask

  // Conflict: load first (d_ready t+3), fetch second (if_ready t+7)
  task automatic test_conflict();
    do_reset();
    cyc(); if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h100;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) cyc();
      mem_rdata = (k == 2) ? 32'hDEAD_BEEF : (k == 6) ? 32'h0000_0013 : (32'h5555_0000 | 32'(k));
      @(negedge clk);
      checks++; if (mem_en !== (k == 1 || k == 2 || k == 5 || k == 6)) begin errors++;
        $display("FAIL conf_en[%0d]: got %b", k, mem_en); end
      checks++; if (stall !== (k <= 7)) begin errors++;
        $display("FAIL conf_stall[%0d]: got %b expected %b", k, stall, (k <= 7)); end
      checks++; if (d_ready !== (k == 3) || if_ready !== (k == 7)) begin errors++;
        $display("FAIL conf_ready[%0d]: got d=%b i=%b expected d=%b i=%b", k, d_ready, if_ready, (k == 3), (k == 7)); end
      if (k == 1 || k == 2) begin
        checks++; if (mem_addr !== 32'h100) begin errors++;
          $display("FAIL conf_daddr[%0d]: got %h expected 00000100", k, mem_addr); end
      end
      if (k == 5 || k == 6) begin
        checks++; if (mem_addr !== 32'h44) begin errors++;
          $display("FAIL conf_iaddr[%0d]: got %h expected 00000044", k, mem_addr); end
      end
      if (k >= 3) begin
        checks++; if (d_rdata !== 32'hDEAD_BEEF) begin errors++;
          $display("FAIL conf_drdata[%0d]: got %h expected deadbeef", k, d_rdata); end
      end
      if (k >= 7) begin
        checks++; if (if_rdata !== 32'h13) begin errors++;
          $display("FAIL conf_irdata[%0d]: got %h expected 00000013", k, if_rdata); end
      end
    end
`ifdef MEM_ARB_PERF_EN
    checks++; if (perf_stall !== 32'd8 || perf_conf !== 32'd4) begin errors++;
      $display("FAIL conf_perf: got %0d/%0d expected 8/4", perf_stall, perf_conf); end
`else
    checks++; if (perf_stall !== 32'd0 || perf_conf !== 32'd0) begin errors++;
      $display("FAIL conf_perf_off: got %0d/%0d expected 0/0", perf_stall, perf_conf); end
`endif
    if_req = 0; d_req = 0;
    cyc();
  endtask

  // Store: mem_we with stable addr/data for 2 cycles, d_rdata untouched
  task automatic test_store();
    cyc(); d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'h1234_5678; mem_rdata = 32'hBAD0_BAD0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      checks++; if (mem_en !== (k == 1 || k == 2) || mem_we !== (k == 1 || k == 2)) begin errors++;
        $display("FAIL store_en[%0d]: got en=%b we=%b", k, mem_en, mem_we); end
      if (k == 1 || k == 2) begin
        checks++; if (mem_addr !== 32'h104 || mem_wdata !== 32'h1234_5678) begin errors++;
          $display("FAIL store_bus[%0d]: got %h/%h expected 00000104/12345678", k, mem_addr, mem_wdata); end
      end
      checks++; if (d_ready !== (k == 3) || stall !== (k <= 3)) begin errors++;
        $display("FAIL store_rdy[%0d]: got rdy=%b stall=%b", k, d_ready, stall); end
      checks++; if (d_rdata !== 32'hDEAD_BEEF) begin errors++;
        $display("FAIL store_drdata[%0d]: got %h expected deadbeef", k, d_rdata); end
    end
    d_req = 0; d_we = 0;
    cyc();
  endtask

  // Held fetch request: one access per instruction, 5 cycles each
  task automatic test_held();
    int n_en = 0, n_rdy = 0;
    logic adv = 0;
    cyc(); if_req = 1; if_addr = 32'h200;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) begin
        cyc();
        if (adv) if_addr = if_addr + 32'd4;
      end
      mem_rdata = {16'hC0DE, mem_addr[15:0]};
      @(negedge clk);
      if (mem_en) n_en++;
      if (if_ready) begin
        n_rdy++;
        checks++; if (if_rdata !== {16'hC0DE, if_addr[15:0]}) begin errors++;
          $display("FAIL held_rdata[%0d]: got %h expected %h", k, if_rdata, {16'hC0DE, if_addr[15:0]}); end
      end
      adv = !stall;
    end
    checks++; if (n_en != 6) begin errors++;
      $display("FAIL held_en_cycles: got %0d expected 6", n_en); end
    checks++; if (n_rdy != 3) begin errors++;
      $display("FAIL held_ready_count: got %0d expected 3", n_rdy); end
    if_req = 0;
    cyc();
  endtask

  // Reset during the second busy cycle abandons the access
  task automatic test_reset_mid();
    cyc(); if_req = 1; if_addr = 32'h80; mem_rdata = 32'h0BAD_F00D;
    cyc(); @(negedge clk);
    checks++; if (mem_en !== 1'b1) begin errors++;
      $display("FAIL rstmid_busy1: got %b expected 1", mem_en); end
    cyc(); rst = 1; if_req = 0;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1) begin errors++;
      $display("FAIL rstmid_busy2: got %b expected 1", mem_en); end
    cyc(); rst = 0;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      checks++; if ({mem_en, mem_we, if_ready, d_ready, stall} !== 5'b0) begin errors++;
        $display("FAIL rstmid_ctrl[%0d]: got %b expected 00000", k, {mem_en, mem_we, if_ready, d_ready, stall}); end
      checks++; if ({if_rdata, d_rdata, mem_addr, perf_stall, perf_conf} !== 160'd0) begin errors++;
        $display("FAIL rstmid_data[%0d]: got %h expected 0", k, {if_rdata, d_rdata, mem_addr, perf_stall, perf_conf}); end
    end
  endtask

  // MEM_LAT=1: single busy cycle, if_ready at t+2
  task automatic test_lat1();
    cyc(); b_if_req = 1; b_if_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      b_mem_rdata = (k == 1) ? 32'h2008_0005 : (32'h7777_0000 | 32'(k));
      @(negedge clk);
      checks++; if (b_mem_en !== (k == 1) || b_if_ready !== (k == 2) || b_stall !== (k <= 2)) begin errors++;
        $display("FAIL lat1[%0d]: got en=%b rdy=%b stall=%b", k, b_mem_en, b_if_ready, b_stall); end
      if (k == 1) begin
        checks++; if (b_mem_addr !== 32'h40) begin errors++;
          $display("FAIL lat1_addr: got %h expected 00000040", b_mem_addr); end
      end
      if (k >= 2) begin
        checks++; if (b_if_rdata !== 32'h2008_0005) begin errors++;
          $display("FAIL lat1_rdata[%0d]: got %h expected 20080005", k, b_if_rdata); end
      end
    end
    b_if_req = 0;
    cyc();
  endtask

  task automatic test_saturation();
    sc_clr = 1; sc_en = 1;
    cyc(); @(negedge clk);
    checks++; if (sc_count !== 32'd0) begin errors++;
      $display("FAIL sat_clr: got %h expected 0", sc_count); end
    sc_clr = 0;
    cyc(); @(negedge clk);
    checks++; if (sc_count !== 32'd1) begin errors++;
      $display("FAIL sat_inc: got %h expected 1", sc_count); end
    sc_en = 0; sc_load = 1; sc_load_val = 32'hFFFF_FFFE;
    cyc(); @(negedge clk);
    checks++; if (sc_count !== 32'hFFFF_FFFE) begin errors++;
      $display("FAIL sat_load: got %h expected fffffffe", sc_count); end
    sc_load = 0; sc_en = 1;
    for (int k = 0; k < 3; k++) begin
      cyc(); @(negedge clk);
      checks++; if (sc_count !== 32'hFFFF_FFFF) begin errors++;
        $display("FAIL sat_hold[%0d]: got %h expected ffffffff", k, sc_count); end
    end
    sc_en = 0; sc_clr = 1;
    cyc(); @(negedge clk);
    checks++; if (sc_count !== 32'd0) begin errors++;
      $display("FAIL sat_reclr: got %h expected 0", sc_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_conflict();
    test_store();
    test_held();
    test_reset_mid();
    test_lat1();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
